// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings for the datapath command sequencer: FSM states, command codes and
// the op bit understood by the inc/dec counter datapath.
package datapath_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StClear = 2'b01,
        StStep  = 2'b10,
        StDone  = 2'b11
    } ctrl_state_e;

    typedef logic [1:0] cmd_code_t;

    localparam cmd_code_t CMD_CLR     = 2'b00;
    localparam cmd_code_t CMD_INC     = 2'b01;
    localparam cmd_code_t CMD_DEC     = 2'b10;
    localparam cmd_code_t CMD_DEC_SAT = 2'b11;

    localparam logic OP_INC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    function automatic logic op_for(input cmd_code_t code);
        return (code == CMD_DEC || code == CMD_DEC_SAT) ? OP_DEC : OP_INC;
    endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Command handshake between a requester (top-level control or register file) and
// the datapath sequencer.
interface datapath_ctrl_if
    import datapath_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    cmd_code_t        cmd_code;
    logic [CNT_W-1:0] cmd_n;

    modport master (output cmd_valid, output cmd_code, output cmd_n, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, input cmd_n, output cmd_ready);
endinterface

// File: rtl/datapath_ctrl.sv
// Expands one accepted command into a burst of c_ld pulses or a single c_clr pulse
// for the inc/dec counter datapath, and signals completion with a one-cycle done.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    datapath_ctrl_if.slave       cmd,
    output logic                 op,
    output logic                 c_ld,
    output logic                 c_clr,
    input  logic                 z,
    input  logic                 m,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_hit,
    output logic [CNT_W-1:0]     steps_done
);

    ctrl_state_e      state_q, state_d;
    cmd_code_t        code_q, code_d;
    logic             op_q, op_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] steps_q, steps_d;

    // Sign bit of the count is informational only; the sequencer never acts on it.
    logic unused_m;
    assign unused_m = m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            code_q  <= CMD_CLR;
            op_q    <= OP_INC;
            sat_q   <= 1'b0;
            rem_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            op_q    <= op_d;
            sat_q   <= sat_d;
            rem_q   <= rem_d;
            steps_q <= steps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        op_d    = op_q;
        sat_d   = sat_q;
        rem_d   = rem_q;
        steps_d = steps_q;
        c_ld    = 1'b0;
        c_clr   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd.cmd_valid) begin
                    code_d  = cmd.cmd_code;
                    op_d    = op_for(cmd.cmd_code);
                    rem_d   = cmd.cmd_n;
                    steps_d = '0;
                    sat_d   = 1'b0;
                    if (cmd.cmd_code == CMD_CLR) begin
                        state_d = StClear;
                    end else if (cmd.cmd_n == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StStep;
                    end
                end
            end
            StClear: begin
                c_clr   = 1'b1;
                state_d = StDone;
            end
            StStep: begin
                // Saturating decrement stops on z before issuing the step that would wrap.
                if (code_q == CMD_DEC_SAT && z) begin
                    sat_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    c_ld    = 1'b1;
                    steps_d = steps_q + CNT_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign cmd.cmd_ready = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign op            = op_q;
    assign sat_hit       = sat_q;
    assign steps_done    = steps_q;

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Command sequencer for the 16-bit inc/dec counter datapath (`datapath`: `op`, `c_ld`, `c_clr` in; `z`, `m`, `c_out` out). It accepts one command at a time over a valid/ready handshake and expands it into a burst of `c_ld` pulses or a single `c_clr` pulse. It monitors `z` to support a saturating decrement and reports completion with a one-cycle `done` pulse. It sits between the top-level control (or a bus register file) and the datapath.

## Interface
- `CNT_W`, default 16: width of the step-count field `cmd_n` and of `steps_done`.
- `clk`  in  1  rising-edge clock; the same clock as `datapath`.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_code`  in  2  command: 00 CLR, 01 INC, 10 DEC, 11 DEC_SAT.
- `cmd_n`  in  CNT_W  number of steps, unsigned; ignored for CLR.
- `op`  out  1  to datapath; 0 = increment, 1 = decrement.
- `c_ld`  out  1  to datapath; a step is applied at each edge where it is high.
- `c_clr`  out  1  to datapath; C := 0.
- `z`  in  1  from datapath; high when C == 0.
- `m`  in  1  from datapath; high when C[15] == 1.
- `busy`  out  1  command in progress (state ≠ IDLE).
- `done`  out  1  one-cycle completion pulse.
- `sat_hit`  out  1  the last DEC_SAT stopped early on `z`; valid from `done` until the next accept.
- `steps_done`  out  CNT_W  number of `c_ld` pulses issued by the last command; valid from `done` until the next accept.

## Operation
- States: IDLE, CLEAR, STEP, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, latch `cmd_code`, `cmd_n` and the op bit, clear `steps_done` and `sat_hit`, then transition:
  - CLR → CLEAR.
  - INC/DEC/DEC_SAT with `cmd_n`=0 → DONE.
  - Otherwise → STEP.
- CLEAR: `c_clr`=1 for exactly one cycle, then → DONE.
- STEP: `op` is held from the latched code (INC=0, DEC/DEC_SAT=1).
  - `c_ld` = 1, except in DEC_SAT when `z`=1.
  - Each cycle with `c_ld` high: increment `steps_done` and decrement the remaining count.
  - When the remaining count reaches 0, or a DEC_SAT sees `z`=1 → DONE. On a DEC_SAT `z`-stop, `sat_hit`:=1 and no `c_ld` is issued that cycle.
- DONE: `done`=1 for one cycle, then → IDLE.
- `c_ld` and `c_clr` are never high together. `c_ld` is high only in STEP.
- Wrap-around: INC from 0xFFFF and DEC from 0 wrap inside the datapath. The controller does not react to them; `m` is informational only and is not used by the FSM.
- `cmd_valid` outside IDLE is ignored; the command is not lost as long as the requester holds `cmd_valid` high.
- Reset values: state=IDLE; `cmd_ready`=1; `op`, `c_ld`, `c_clr`, `busy`, `done`, `sat_hit`=0; `steps_done`=0.
- Reset mid-command aborts immediately; no further `c_ld`/`c_clr` pulses are issued. The datapath keeps whatever partial count it reached unless it is reset too.

## Timing
- Accept at edge k.
- INC/DEC, n>0:
  - `c_ld` high for cycles k..k+n-1, contiguous: n datapath updates.
  - `done` in cycle k+n.
  - `cmd_ready` high again in cycle k+n+1.
- CLR: `c_clr` in cycle k, `done` in k+1.
- n=0: `done` in k, no pulses.
- DEC_SAT: stops at the first STEP cycle with `z`=1. With C=j<n, `c_ld` is high for j cycles and `done` follows in cycle k+j+1.
- `z` is combinational from the datapath register, so it reflects all prior loads; there is no combinational loop.
- Back-to-back throughput: one command per (length+2) cycles.

## Structure
- `datapath_ctrl_pkg`: state enum, `cmd_code` constants (CMD_CLR, CMD_INC, CMD_DEC, CMD_DEC_SAT), and the OP_INC/OP_DEC encodings shared with `datapath`.
- No sub-module is needed: the FSM and the step counter are implemented inline.
- Top-level integration (`datapath` + `datapath_ctrl`) goes in a separate wrapper.

## Test plan
- Reset, then INC n=3 → `c_ld` high for 3 contiguous cycles, `c_out`=3, `done` once, `steps_done`=3, `sat_hit`=0.
- DEC n=5 from C=3 → `c_out`=0xFFFE, `m`=1, `steps_done`=5.
- CLR → a single `c_clr` pulse, `c_out`=0, `z`=1, `done` one cycle after accept.
- DEC_SAT n=10 from C=4 → 4 `c_ld` pulses, `c_out`=0, `sat_hit`=1, `steps_done`=4. A following DEC_SAT n=2 from C=0 → 0 pulses, `sat_hit`=1.
- INC n=0 → `done` in the accept cycle, no `c_ld`. Also check `cmd_valid` held during a busy INC n=4: that command is accepted exactly once, the cycle after `done`.
- `reset` asserted during INC n=8 after 3 pulses → outputs return to reset values in the same cycle, no further `c_ld`, `cmd_ready`=1.
